// File: rtl/ff_step_clock_ctrl.sv
// Step-pulse generator for the lab flip-flop bank: debounced step/stop buttons
// drive single, burst, and free-run clock-enable sequencing.
module ff_step_clock_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PRESCALE        = 5000000,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_step_n,
    input  logic             btn_stop_n,
    input  logic [1:0]       mode,
    input  logic [3:0]       burst_len,
    output logic             step_pulse,
    output logic             busy,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] step_count
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01,
        RUN   = 2'b10
    } state_e;

    // Bit 0 is the step button, bit 1 the stop button.
    logic [1:0]         raw;
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         smp;
    logic [1:0]         deb_q, deb_d;
    logic [1:0]         press_q, press_d;
    logic [1:0][DW-1:0] dcnt_q, dcnt_d;

    state_e             state_q, state_d;
    logic [3:0]         rem_q, rem_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic               pulse_q, pulse_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               press_step, press_stop, tick;

    assign raw = {btn_stop_n, btn_step_n};
    assign smp = ~sync2_q;

    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (smp[i] != deb_q[i]) begin
                if (dcnt_q[i] == DMAX) begin
                    deb_d[i] = smp[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
        press_d = deb_d & ~deb_q;
    end

    assign press_step = press_q[0];
    assign press_stop = press_q[1];
    assign tick       = (presc_q == PMAX);

    // Prescaler stays at zero in IDLE, so every BURST/RUN entry starts fresh.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        presc_d = '0;
        pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press_step && !press_stop) begin
                    case (mode)
                        2'b00: pulse_d = 1'b1;
                        2'b01: begin
                            if (burst_len != 4'd0) begin
                                rem_d   = burst_len;
                                state_d = BURST;
                            end
                        end
                        2'b10: state_d = RUN;
                        default: ;
                    endcase
                end
            end
            BURST, RUN: begin
                if (press_step || press_stop) begin
                    state_d = IDLE;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        pulse_d = 1'b1;
                        if (state_q == BURST) begin
                            rem_d = rem_q - 4'd1;
                            if (rem_q == 4'd1) state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign count_d = count_q + CNT_W'(pulse_d);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            deb_q   <= '0;
            dcnt_q  <= '0;
            press_q <= '0;
            state_q <= IDLE;
            rem_q   <= '0;
            presc_q <= '0;
            pulse_q <= 1'b0;
            count_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            dcnt_q  <= dcnt_d;
            press_q <= press_d;
            state_q <= state_d;
            rem_q   <= rem_d;
            presc_q <= presc_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
        end
    end

    assign step_pulse = pulse_q;
    assign busy       = (state_q != IDLE);
    assign state      = state_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_ff_step_clock_ctrl.sv
// Directed bench for ff_step_clock_ctrl with DEBOUNCE_CYCLES=4, PRESCALE=3.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_ff_step_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_step_n = 1'b1;
    logic       btn_stop_n = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [3:0] burst_len = 4'd0;
    logic       step_pulse;
    logic       busy;
    logic [1:0] state;
    logic [7:0] step_count;

    ff_step_clock_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .PRESCALE(3),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_step_n(btn_step_n),
        .btn_stop_n(btn_stop_n),
        .mode(mode),
        .burst_len(burst_len),
        .step_pulse(step_pulse),
        .busy(busy),
        .state(state),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail = 0;
    int   cnum = 0;
    int   npulse = 0;
    int   entry = -1;
    int   exit_c = -1;
    int   pq[$];
    logic prev_busy = 1'b0;
    logic prev_pulse = 1'b0;
    logic saw_busy = 1'b0;
    logic two_in_row = 1'b0;

    task automatic cyc();
        @(posedge clk);
        #1;
        cnum++;
        if (step_pulse === 1'b1) begin
            npulse++;
            pq.push_back(cnum);
        end
        if (step_pulse === 1'b1 && prev_pulse === 1'b1) two_in_row = 1'b1;
        prev_pulse = step_pulse;
        if (busy === 1'b1 && prev_busy !== 1'b1) entry = cnum;
        if (busy !== 1'b1 && prev_busy === 1'b1) exit_c = cnum;
        if (busy === 1'b1) saw_busy = 1'b1;
        prev_busy = busy;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic clr();
        npulse = 0;
        pq.delete();
        entry = -1;
        exit_c = -1;
        saw_busy = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int lim, input string tag);
        int k;
        k = 0;
        while (busy !== lvl && k < lim) begin
            cyc();
            k++;
        end
        chk(tag, 32'(busy), 32'(lvl));
    endtask

    function automatic int count_between(input int lo, input int hi);
        int n;
        n = 0;
        foreach (pq[i]) if (pq[i] > lo && pq[i] <= hi) n++;
        return n;
    endfunction

    initial begin
        int first;
        int last;
        int e;
        int exp_wrap[3];
        exp_wrap = '{255, 0, 1};

        // Reset state
        cyc();
        cyc();
        chk("rst_state", 32'(state), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pulse", 32'(step_pulse), 0);
        chk("rst_count", 32'(step_count), 0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_pulse", 32'(step_pulse), 0);

        // Two-cycle glitch must be rejected
        clr();
        btn_step_n = 1'b0;
        cyc();
        cyc();
        btn_step_n = 1'b1;
        repeat (12) cyc();
        chk("glitch_pulses", 32'(npulse), 0);
        chk("glitch_count", 32'(step_count), 0);

        // Single step with a long hold
        clr();
        mode = 2'b00;
        btn_step_n = 1'b0;
        repeat (20) cyc();
        btn_step_n = 1'b1;
        repeat (12) cyc();
        chk("single_pulses", 32'(npulse), 1);
        chk("single_count", 32'(step_count), 1);
        chk("single_state", 32'(state), 0);
        chk("single_busy", 32'(saw_busy), 0);

        // Burst of 4, inputs changed after start
        clr();
        mode = 2'b01;
        burst_len = 4'd4;
        btn_step_n = 1'b0;
        wait_busy(1'b1, 20, "burst_entry");
        chk("burst_state", 32'(state), 1);
        btn_step_n = 1'b1;
        mode = 2'b10;
        burst_len = 4'd0;
        repeat (20) cyc();
        first = (pq.size() > 0) ? pq[0] : -100;
        last = (pq.size() > 0) ? pq[pq.size()-1] : -100;
        chk("burst_pulses", 32'(npulse), 4);
        chk("burst_first_lat", 32'(first - entry), 3);
        chk("burst_span", 32'(last - first), 9);
        chk("burst_exit", 32'(exit_c - entry), 12);
        chk("burst_end_state", 32'(state), 0);
        chk("burst_count", 32'(step_count), 5);

        // Free run, mode change ignored, then stop
        clr();
        mode = 2'b10;
        btn_step_n = 1'b0;
        wait_busy(1'b1, 20, "run_entry");
        btn_step_n = 1'b1;
        chk("run_state", 32'(state), 2);
        mode = 2'b11;
        e = entry;
        repeat (30) cyc();
        chk("run_window", 32'(count_between(e, e + 30)), 10);
        chk("run_still_busy", 32'(busy), 1);
        btn_stop_n = 1'b0;
        wait_busy(1'b0, 20, "run_stop");
        btn_stop_n = 1'b1;
        repeat (12) cyc();
        chk("run_after_stop", 32'(count_between(exit_c - 1, cnum)), 0);
        chk("run_pulses", 32'(npulse), 12);
        chk("run_count", 32'(step_count), 17);
        chk("run_end_state", 32'(state), 0);

        // Burst of 15 cut short by simultaneous stop+step
        clr();
        mode = 2'b01;
        burst_len = 4'd15;
        btn_step_n = 1'b0;
        repeat (4) cyc();
        btn_step_n = 1'b1;
        wait_busy(1'b1, 10, "b15_entry");
        cyc();
        btn_step_n = 1'b0;
        btn_stop_n = 1'b0;
        repeat (6) cyc();
        btn_step_n = 1'b1;
        btn_stop_n = 1'b1;
        wait_busy(1'b0, 20, "b15_abort");
        repeat (15) cyc();
        chk("b15_pulses", 32'(npulse), 2);
        chk("b15_count", 32'(step_count), 19);
        chk("b15_state", 32'(state), 0);

        // Burst length zero is ignored
        clr();
        burst_len = 4'd0;
        btn_step_n = 1'b0;
        repeat (8) cyc();
        btn_step_n = 1'b1;
        repeat (12) cyc();
        chk("len0_busy", 32'(saw_busy), 0);
        chk("len0_pulses", 32'(npulse), 0);
        chk("len0_count", 32'(step_count), 19);

        // Counter wrap after 254 single steps
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("wrap_rst_count", 32'(step_count), 0);
        clr();
        mode = 2'b00;
        repeat (254) begin
            btn_step_n = 1'b0;
            repeat (5) cyc();
            btn_step_n = 1'b1;
            repeat (6) cyc();
        end
        chk("preload_pulses", 32'(npulse), 254);
        chk("preload_count", 32'(step_count), 254);
        for (int k = 0; k < 3; k++) begin
            btn_step_n = 1'b0;
            repeat (5) cyc();
            btn_step_n = 1'b1;
            repeat (6) cyc();
            chk($sformatf("wrap_%0d", k), 32'(step_count), 32'(exp_wrap[k]));
        end

        // Reset in the middle of a run
        clr();
        mode = 2'b10;
        btn_step_n = 1'b0;
        wait_busy(1'b1, 20, "run2_entry");
        btn_step_n = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b0;
        cyc();
        chk("midrst_pulse", 32'(step_pulse), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_state", 32'(state), 0);
        chk("midrst_count", 32'(step_count), 0);
        rst_n = 1'b1;
        repeat (10) cyc();
        chk("midrst_no_pulse", 32'(npulse), 0);
        chk("no_back_to_back", 32'(two_in_row), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
